// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the IFU (read-only) and the LSU (read/write).
// One outstanding transaction at a time, round-robin on ties, with ID check and watchdog.
module axi_master_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_ifu_req,
  input  logic                i_lsu_req,
  input  logic                i_lsu_we,
  output logic                o_ifu_grant,
  output logic                o_lsu_grant,
  input  logic                i_ifu_arvalid,
  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  input  logic [ID_W-1:0]     i_ifu_arid,
  input  logic [7:0]          i_ifu_arlen,
  input  logic [2:0]          i_ifu_arsize,
  input  logic [1:0]          i_ifu_arburst,
  output logic                o_ifu_arready,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  output logic                o_ifu_rlast,
  output logic [ID_W-1:0]     o_ifu_rid,
  output logic                o_ifu_rvalid,
  input  logic                i_ifu_rready,
  input  logic                i_lsu_arvalid,
  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  input  logic [ID_W-1:0]     i_lsu_arid,
  input  logic [7:0]          i_lsu_arlen,
  input  logic [2:0]          i_lsu_arsize,
  input  logic [1:0]          i_lsu_arburst,
  output logic                o_lsu_arready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  output logic                o_lsu_rlast,
  output logic [ID_W-1:0]     o_lsu_rid,
  output logic                o_lsu_rvalid,
  input  logic                i_lsu_rready,
  input  logic                i_lsu_awvalid,
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  input  logic [ID_W-1:0]     i_lsu_awid,
  input  logic [7:0]          i_lsu_awlen,
  input  logic [2:0]          i_lsu_awsize,
  input  logic [1:0]          i_lsu_awburst,
  output logic                o_lsu_awready,
  input  logic                i_lsu_wvalid,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic                i_lsu_wlast,
  output logic                o_lsu_wready,
  output logic                o_lsu_bvalid,
  output logic [1:0]          o_lsu_bresp,
  output logic [ID_W-1:0]     o_lsu_bid,
  input  logic                i_lsu_bready,
  output logic                o_m_arvalid,
  output logic [ADDR_W-1:0]   o_m_araddr,
  output logic [ID_W-1:0]     o_m_arid,
  output logic [7:0]          o_m_arlen,
  output logic [2:0]          o_m_arsize,
  output logic [1:0]          o_m_arburst,
  input  logic                i_m_arready,
  input  logic [DATA_W-1:0]   i_m_rdata,
  input  logic [1:0]          i_m_rresp,
  input  logic                i_m_rlast,
  input  logic [ID_W-1:0]     i_m_rid,
  input  logic                i_m_rvalid,
  output logic                o_m_rready,
  output logic                o_m_awvalid,
  output logic [ADDR_W-1:0]   o_m_awaddr,
  output logic [ID_W-1:0]     o_m_awid,
  output logic [7:0]          o_m_awlen,
  output logic [2:0]          o_m_awsize,
  output logic [1:0]          o_m_awburst,
  input  logic                i_m_awready,
  output logic                o_m_wvalid,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_wstrb,
  output logic                o_m_wlast,
  input  logic                i_m_wready,
  input  logic                i_m_bvalid,
  input  logic [1:0]          i_m_bresp,
  input  logic [ID_W-1:0]     i_m_bid,
  output logic                o_m_bready,
  output logic                o_id_err,
  output logic                o_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFU_RD = 2'd1,
    ST_LSU_RD = 2'd2,
    ST_LSU_WR = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ifu_grant;
  logic             r_lsu_grant;
  logic             r_last_lsu;
  logic [ID_W-1:0]  r_cap_id;
  logic             r_id_err;
  logic [CNT_W-1:0] r_wdog;
  logic             r_timeout;

  logic w_rd_done;
  logic w_wr_done;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_r_beat;
  logic w_b_beat;

  // Readies toward the SoC are zero unless a state owns that channel.
  assign w_ar_hs   = o_m_arvalid & i_m_arready;
  assign w_aw_hs   = o_m_awvalid & i_m_awready;
  assign w_r_beat  = i_m_rvalid & o_m_rready;
  assign w_b_beat  = i_m_bvalid & o_m_bready;
  assign w_rd_done = w_r_beat & i_m_rlast;
  assign w_wr_done = w_b_beat;

  assign o_ifu_grant = r_ifu_grant;
  assign o_lsu_grant = r_lsu_grant;
  assign o_id_err    = r_id_err;
  assign o_timeout   = r_timeout;

  // State register; grants are registered copies of the next owner.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ifu_grant <= 1'b0;
      r_lsu_grant <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ifu_grant <= (w_state_nxt == ST_IFU_RD);
      r_lsu_grant <= (w_state_nxt == ST_LSU_RD) || (w_state_nxt == ST_LSU_WR);
    end
  end

  // Next state: round-robin on ties, release on the completing beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_ifu_req && i_lsu_req) begin
          if (r_last_lsu) w_state_nxt = ST_IFU_RD;
          else            w_state_nxt = i_lsu_we ? ST_LSU_WR : ST_LSU_RD;
        end else if (i_ifu_req) begin
          w_state_nxt = ST_IFU_RD;
        end else if (i_lsu_req) begin
          w_state_nxt = i_lsu_we ? ST_LSU_WR : ST_LSU_RD;
        end
      end
      ST_IFU_RD, ST_LSU_RD: if (w_rd_done) w_state_nxt = ST_IDLE;
      ST_LSU_WR:            if (w_wr_done) w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Channel routing: only the owner's channels are connected through.
  always_comb begin
    o_m_arvalid   = 1'b0;
    o_m_araddr    = '0;
    o_m_arid      = '0;
    o_m_arlen     = '0;
    o_m_arsize    = '0;
    o_m_arburst   = '0;
    o_m_rready    = 1'b0;
    o_m_awvalid   = 1'b0;
    o_m_awaddr    = '0;
    o_m_awid      = '0;
    o_m_awlen     = '0;
    o_m_awsize    = '0;
    o_m_awburst   = '0;
    o_m_wvalid    = 1'b0;
    o_m_wdata     = '0;
    o_m_wstrb     = '0;
    o_m_wlast     = 1'b0;
    o_m_bready    = 1'b0;
    o_ifu_arready = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rdata   = i_m_rdata;
    o_ifu_rresp   = i_m_rresp;
    o_ifu_rlast   = i_m_rlast;
    o_ifu_rid     = i_m_rid;
    o_lsu_arready = 1'b0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rdata   = i_m_rdata;
    o_lsu_rresp   = i_m_rresp;
    o_lsu_rlast   = i_m_rlast;
    o_lsu_rid     = i_m_rid;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bvalid  = 1'b0;
    o_lsu_bresp   = i_m_bresp;
    o_lsu_bid     = i_m_bid;
    case (r_state)
      ST_IFU_RD: begin
        o_m_arvalid   = i_ifu_arvalid;
        o_m_araddr    = i_ifu_araddr;
        o_m_arid      = i_ifu_arid;
        o_m_arlen     = i_ifu_arlen;
        o_m_arsize    = i_ifu_arsize;
        o_m_arburst   = i_ifu_arburst;
        o_ifu_arready = i_m_arready;
        o_ifu_rvalid  = i_m_rvalid;
        o_m_rready    = i_ifu_rready;
      end
      ST_LSU_RD: begin
        o_m_arvalid   = i_lsu_arvalid;
        o_m_araddr    = i_lsu_araddr;
        o_m_arid      = i_lsu_arid;
        o_m_arlen     = i_lsu_arlen;
        o_m_arsize    = i_lsu_arsize;
        o_m_arburst   = i_lsu_arburst;
        o_lsu_arready = i_m_arready;
        o_lsu_rvalid  = i_m_rvalid;
        o_m_rready    = i_lsu_rready;
      end
      ST_LSU_WR: begin
        o_m_awvalid   = i_lsu_awvalid;
        o_m_awaddr    = i_lsu_awaddr;
        o_m_awid      = i_lsu_awid;
        o_m_awlen     = i_lsu_awlen;
        o_m_awsize    = i_lsu_awsize;
        o_m_awburst   = i_lsu_awburst;
        o_lsu_awready = i_m_awready;
        o_m_wvalid    = i_lsu_wvalid;
        o_m_wdata     = i_lsu_wdata;
        o_m_wstrb     = i_lsu_wstrb;
        o_m_wlast     = i_lsu_wlast;
        o_lsu_wready  = i_m_wready;
        o_lsu_bvalid  = i_m_bvalid;
        o_m_bready    = i_lsu_bready;
      end
      default: ;
    endcase
  end

  // Bookkeeping: last-served, ID capture/check, ownership watchdog.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_lsu <= 1'b0;
      r_cap_id   <= '0;
      r_id_err   <= 1'b0;
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_rd_done || w_wr_done) r_last_lsu <= (r_state != ST_IFU_RD);
      if (w_ar_hs)      r_cap_id <= o_m_arid;
      else if (w_aw_hs) r_cap_id <= o_m_awid;
      r_id_err <= (w_r_beat && (i_m_rid != r_cap_id)) ||
                  (w_b_beat && (i_m_bid != r_cap_id));
      if (r_state == ST_IDLE || w_rd_done || w_wr_done) begin
        r_wdog <= '0;
      end else if (r_wdog != CNT_W'(TIMEOUT)) begin
        r_wdog <= r_wdog + CNT_W'(1);
        if (r_wdog == CNT_W'(TIMEOUT - 1)) r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Shares the single SoC AXI4 master port between the instruction-fetch unit (IFU, read-only, ID 0) and the load/store unit (LSU, read/write, ID 1).
- Owns the grant handshake that each unit waits on before raising arvalid/awvalid.
- Serialises transactions: exactly one outstanding AXI transaction at a time.
- Routes channels between the granted master and the SoC, and watches for hung transactions.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB width = DATA_W/8
- ID_W, 4, AXI ID width
- TIMEOUT, 1024, cycles of ownership without completion before the timeout flag sets

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- ifu_req  input  1  IFU requests bus (level, held until grant)
- lsu_req  input  1  LSU requests bus (level, held until grant)
- lsu_we  input  1  LSU request is a write (sampled at grant)
- ifu_grant  output  1  IFU owns bus
- lsu_grant  output  1  LSU owns bus
- ifu_ar{valid,addr,id,len,size,burst} / ifu_arready  in/out  1,ADDR_W,ID_W,8,3,2 / 1  IFU read-address channel
- ifu_r{data,resp,last,id,valid} / ifu_rready  out/in  DATA_W,2,1,ID_W,1 / 1  IFU read-data channel
- lsu_ar*, lsu_r*  as IFU  LSU read channels
- lsu_aw{valid,addr,id,len,size,burst} / lsu_awready  in/out  1,ADDR_W,ID_W,8,3,2 / 1  LSU write-address channel
- lsu_w{valid,data,strb,last} / lsu_wready  in/out  1,DATA_W,DATA_W/8,1 / 1  LSU write-data channel
- lsu_b{valid,resp,id} / lsu_bready  out/in  1,2,ID_W / 1  LSU write-response channel
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror  same widths  SoC master port, directions inverted
- id_err  output  1  one-cycle pulse: response ID differs from the owner's captured ID
- timeout  output  1  sticky: ownership exceeded TIMEOUT cycles

Behaviour:
- State machine: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Reset values: state IDLE; ifu_grant=0, lsu_grant=0; id_err=0; timeout=0; last_served=IFU; watchdog counter=0; all m_*valid, m_rready, m_bready, and all master-side ready/valid outputs are 0.
- Arbitration in IDLE:
  - Only ifu_req: go to IFU_RD.
  - Only lsu_req: go to LSU_WR if lsu_we=1, else LSU_RD.
  - Both requests: grant the master that is not last_served, i.e. round-robin. After reset, LSU wins the first tie.
  - No request: stay in IDLE.
- Grant timing: grants are registered, one-hot and equal to state ownership. A request sampled at edge N gives a grant visible after edge N, which is the cycle the master may assert its valid. A request dropped before it is sampled is never granted.
- Routing while owned:
  - Owner's AR/AW/W/B/R pass combinationally to and from m_*.
  - The non-owner sees all readies and response valids at 0.
  - In IDLE, m_arvalid, m_awvalid and m_wvalid are 0 and m_rready, m_bready are 0.
  - In IFU_RD and LSU_RD, the AW/W/B channels are held inactive.
- Completion and release:
  - Read states complete on m_rvalid & m_rready & m_rlast. Write state completes on m_bvalid & m_bready.
  - On the completion edge: return to IDLE, clear the grant, update last_served to the owner, clear the watchdog.
  - A new grant is possible at the earliest on the following edge, giving a minimum one idle cycle between transactions.
- Deasserting a request while granted has no effect; ownership is held until completion.
- lsu_we changing after grant is ignored.
- ID check: arid/awid are captured on the AR/AW handshake. Any R or B beat whose ID differs pulses id_err for one cycle. The beat is still forwarded unchanged to the owner.
- Watchdog:
  - Increments every cycle in a non-IDLE state, saturating at TIMEOUT.
  - On reaching TIMEOUT, timeout sets and stays set until reset.
  - State is unaffected; the arbiter does not abort.
- Response errors (rresp/bresp nonzero) are forwarded unchanged; the arbiter does not act on them.
- Reset mid-transaction: the next edge forces IDLE and all reset values; in-flight SoC responses are ignored.
- Multi-beat reads (len>0): ownership is held until the rlast beat.

Test Plan:
- Reset, then ifu_req=1 alone, araddr=0x3000_0000, slave answers rdata=0x0000_0413 with rlast → ifu_grant high one cycle after request; data forwarded; grant drops after rlast edge; state IDLE.
- ifu_req and lsu_req rise in the same cycle after reset, lsu_we=0 → lsu_grant first; after its completion plus one idle cycle, ifu_grant. Repeat the tie → IFU then LSU (round-robin).
- LSU write to 0x0f00_0010, wdata=0xdead_beef, wstrb=0xF, slave delays bvalid 5 cycles → m_w* matches exactly; lsu_grant held through the delay; IFU request pending throughout is granted only after the bvalid handshake.
- IFU owns bus; inject rvalid with rid=1 while the captured arid=0 → id_err single-cycle pulse; data still delivered to IFU; lsu_rvalid stays 0.
- TIMEOUT=16, slave never responds to an IFU AR → timeout sets at cycle 16 of ownership and stays set; deassert rstn mid-transaction → grants 0, state IDLE, timeout 0 after the next edge.
- Burst read with arlen=3 → grant held for exactly 4 R beats; release only on the beat with rlast=1.
